oam_dma_controller: RTL and testbench

- Game Boy OAM DMA engine (register FF46) that hangs off the interconnect as a second bus master.
- A CPU write to the DMA register starts a copy of NUM_BYTES bytes from {src_hi, 8'h00} into OAM (FE00-FE9F).
- Reads go through the interconnect master port; writes go on a dedicated OAM write port.
- busy is exported so the interconnect can block CPU access to non-HRAM regions during the copy.

---
 rtl/oam_dma_controller.sv | 183 ++++++++++++++++++
 tb/tb_oam_dma_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// -----------------------------------------------------------------------------
// oam_dma_controller
//
// Game Boy OAM DMA engine (register FF46). A CPU write to the register starts
// a copy of NUM_BYTES bytes from {src_hi, 8'h00} into OAM. Source bytes are
// read through the interconnect master port, and OAM is written through a
// dedicated write port. busy lets the interconnect fence off the CPU while
// a copy is running.
//
// Ports:
//   clock_i        system clock, rising edge
//   reset_i        asynchronous reset, active low
//   reg_wr_en_i    one-cycle CPU write strobe to FF46
//   reg_wr_data_i  source high byte written by the CPU
//   reg_rd_data_o  last value written to FF46 (unmapped)
//   busy_o         copy in progress (start delay + transfer)
//   bus_req_o      master request to the interconnect during the transfer
//   bus_grant_i    interconnect grant; low stalls the slot sequencer
//   bus_addr_o     read address {src_hi, idx}
//   bus_rd_en_o    one-cycle read strobe
//   bus_rd_data_i  read data, valid the cycle after bus_rd_en_o
//   oam_addr_o     OAM byte index
//   oam_wr_en_o    one-cycle OAM write strobe
//   oam_wr_data_o  byte to write into OAM
// -----------------------------------------------------------------------------
module oam_dma_controller #(
    parameter int NUM_BYTES       = 160,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        reg_wr_en_i,
    input  logic [7:0]  reg_wr_data_i,
    output logic [7:0]  reg_rd_data_o,
    output logic        busy_o,
    output logic        bus_req_o,
    input  logic        bus_grant_i,
    output logic [15:0] bus_addr_o,
    output logic        bus_rd_en_o,
    input  logic [7:0]  bus_rd_data_i,
    output logic [7:0]  oam_addr_o,
    output logic        oam_wr_en_o,
    output logic [7:0]  oam_wr_data_o
);

    localparam int CW = $clog2(CYCLES_PER_BYTE);
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_e;

    // With no start delay a write drops straight into the transfer.
    localparam state_e START_TGT = (START_DELAY == 0) ? XFER : START;

    state_e          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [7:0]      idx_q, idx_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [7:0]      src_q, src_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      src_map;

    logic            busy_q, req_q, rd_q, wr_q;
    logic [15:0]     bus_addr_q;
    logic [7:0]      oam_addr_q;
    logic            rd_vld_q;   // a read fired last cycle: bus_rd_data_i is live
    logic [7:0]      data_q;     // captured read byte, used for deferred writes

    // E0-FF is echo RAM for C000-DFFF.
    always_comb begin
        src_map = reg_wr_data_i;
        if (reg_wr_data_i >= 8'hE0) begin
            src_map = reg_wr_data_i - 8'h20;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        src_d   = src_q;
        reg_d   = reg_q;
        if (reg_wr_en_i) begin
            // A write while busy is a restart; same handling as from IDLE.
            reg_d   = reg_wr_data_i;
            src_d   = src_map;
            idx_d   = 8'd0;
            c_d     = '0;
            dly_d   = '0;
            state_d = START_TGT;
        end else begin
            case (state_q)
                START: begin
                    if (dly_q == DW'(START_DELAY - 1)) begin
                        state_d = XFER;
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                XFER: begin
                    // Without grant the slot sequencer freezes in place.
                    if (bus_grant_i) begin
                        if (c_q == CW'(CYCLES_PER_BYTE - 1)) begin
                            c_d = '0;
                            if (idx_q == 8'(NUM_BYTES - 1)) begin
                                state_d = IDLE;
                            end else begin
                                idx_d = idx_q + 8'd1;
                            end
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            c_q        <= '0;
            idx_q      <= 8'd0;
            dly_q      <= '0;
            src_q      <= 8'd0;
            reg_q      <= 8'hFF;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            bus_addr_q <= 16'd0;
            oam_addr_q <= 8'd0;
            rd_vld_q   <= 1'b0;
            data_q     <= 8'd0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            dly_q    <= dly_d;
            src_q    <= src_d;
            reg_q    <= reg_d;
            // Outputs are registered from next state so they line up with
            // the slot position of the cycle they appear in.
            busy_q   <= (state_d != IDLE);
            req_q    <= (state_d == XFER);
            rd_q     <= (state_d == XFER) && (c_d == CW'(0));
            wr_q     <= (state_d == XFER) && (c_d == CW'(1));
            if ((state_d == XFER) && (c_d == CW'(0))) begin
                bus_addr_q <= {src_d, idx_d};
            end
            if ((state_d == XFER) && (c_d == CW'(1))) begin
                oam_addr_q <= idx_d;
            end
            rd_vld_q <= bus_rd_en_o;
            if (rd_vld_q) begin
                data_q <= bus_rd_data_i;
            end
        end
    end

    assign reg_rd_data_o = reg_q;
    assign busy_o        = busy_q;
    assign bus_req_o     = req_q;
    assign bus_addr_o    = bus_addr_q;
    assign oam_addr_o    = oam_addr_q;

    // Grant gates the strobes in the cycle it is low so nothing is issued
    // onto a bus we do not own. A register write kills a pending OAM write.
    assign bus_rd_en_o   = rd_q & bus_grant_i;
    assign oam_wr_en_o   = wr_q & bus_grant_i & ~reg_wr_en_i;

    // Read data is only valid for the single cycle after the read, which is
    // the c=1 write cycle, so that cycle passes it straight through. A write
    // deferred by a grant stall uses the captured copy instead.
    assign oam_wr_data_o = rd_vld_q ? bus_rd_data_i : data_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  // main instance, default parameters
  logic        reg_wr_en = 1'b0;
  logic [7:0]  reg_wr_data = 8'h00;
  logic [7:0]  reg_rd_data;
  logic        busy, bus_req, bus_rd_en, oam_wr_en;
  logic        bus_grant = 1'b1;
  logic [15:0] bus_addr;
  logic [7:0]  bus_rd_data = 8'hEE;
  logic [7:0]  oam_addr, oam_wr_data;

  // small instance for the parameter corner
  logic        s_reg_wr_en = 1'b0;
  logic [7:0]  s_reg_wr_data = 8'h00;
  logic [7:0]  s_reg_rd_data;
  logic        s_busy, s_bus_req, s_bus_rd_en, s_oam_wr_en;
  logic        s_bus_grant = 1'b1;
  logic [15:0] s_bus_addr;
  logic [7:0]  s_bus_rd_data = 8'hEE;
  logic [7:0]  s_oam_addr, s_oam_wr_data;

  oam_dma_controller u_dut (
    .clock_i(clk), .reset_i(rst_n),
    .reg_wr_en_i(reg_wr_en), .reg_wr_data_i(reg_wr_data), .reg_rd_data_o(reg_rd_data),
    .busy_o(busy), .bus_req_o(bus_req), .bus_grant_i(bus_grant),
    .bus_addr_o(bus_addr), .bus_rd_en_o(bus_rd_en), .bus_rd_data_i(bus_rd_data),
    .oam_addr_o(oam_addr), .oam_wr_en_o(oam_wr_en), .oam_wr_data_o(oam_wr_data)
  );

  oam_dma_controller #(.NUM_BYTES(1), .CYCLES_PER_BYTE(2), .START_DELAY(0)) u_dut_s (
    .clock_i(clk), .reset_i(rst_n),
    .reg_wr_en_i(s_reg_wr_en), .reg_wr_data_i(s_reg_wr_data), .reg_rd_data_o(s_reg_rd_data),
    .busy_o(s_busy), .bus_req_o(s_bus_req), .bus_grant_i(s_bus_grant),
    .bus_addr_o(s_bus_addr), .bus_rd_en_o(s_bus_rd_en), .bus_rd_data_i(s_bus_rd_data),
    .oam_addr_o(s_oam_addr), .oam_wr_en_o(s_oam_wr_en), .oam_wr_data_o(s_oam_wr_data)
  );

  // memory model: data = addr_lo ^ addr_hi, one cycle after the read; junk otherwise
  always @(posedge clk) begin
    bus_rd_data   <= bus_rd_en   ? (bus_addr[7:0] ^ bus_addr[15:8])     : 8'hEE;
    s_bus_rd_data <= s_bus_rd_en ? (s_bus_addr[7:0] ^ s_bus_addr[15:8]) : 8'hEE;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];   // {oam_addr, oam_wr_data}

  task automatic push_xfer(input logic [7:0] src);
    for (int k = 0; k < 160; k++) begin
      exp_rd.push_back({src, 8'(k)});
      exp_wr.push_back({8'(k), 8'(k) ^ src});
    end
  endtask

  // monitor
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, run = 0, last_run = 0, done_cnt = 0;
  int rise_cyc = 0, first_rd_cyc = 0;
  bit first_pend = 1'b0, busy_prev = 1'b0;
  logic req_at_rise = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (busy && !busy_prev) begin
      rise_cyc = cyc; first_pend = 1'b1; req_at_rise = bus_req;
    end
    if (busy) run++;
    else if (run != 0) begin last_run = run; run = 0; done_cnt++; end
    busy_prev = busy;
    if (!bus_grant) begin
      chk("stall_rd", bus_rd_en, 0);
      chk("stall_wr", oam_wr_en, 0);
    end
    if (bus_rd_en) begin
      rd_cnt++;
      if (first_pend) begin first_rd_cyc = cyc; first_pend = 1'b0; end
      chk("rd_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) chk("rd_addr", bus_addr, exp_rd.pop_front());
    end
    if (oam_wr_en) begin
      wr_cnt++;
      chk("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) chk("oam_wr", {oam_addr, oam_wr_data}, exp_wr.pop_front());
    end
  end

  // drive a CPU write for one cycle, away from the edge
  task automatic cpu_wr(input logic [7:0] d);
    @(posedge clk); #1;
    reg_wr_en = 1'b1; reg_wr_data = d;
    @(posedge clk); #1;
    reg_wr_en = 1'b0;
  endtask

  task automatic wait_cnt(input bit use_wr, input int target, input int budget);
    int n = 0;
    while (((use_wr ? wr_cnt : rd_cnt) < target) && n < budget) begin
      @(posedge clk); n++;
    end
    chk(use_wr ? "wait_wr" : "wait_rd", (use_wr ? wr_cnt : rd_cnt) >= target, 1);
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      @(posedge clk); n++;
    end
    chk("wait_done", done_cnt != prev, 1);
  endtask

  initial begin
    int bw, bd, br;
    // reset values
    #2 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);        chk("rst_req", bus_req, 0);
    chk("rst_rd_en", bus_rd_en, 0);  chk("rst_wr_en", oam_wr_en, 0);
    chk("rst_addr", bus_addr, 0);    chk("rst_oam_addr", oam_addr, 0);
    chk("rst_wdata", oam_wr_data, 0); chk("rst_reg", reg_rd_data, 8'hFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic copy from C100
    bw = wr_cnt; bd = done_cnt;
    push_xfer(8'hC1);
    cpu_wr(8'hC1);
    chk("reg_rd_c1", reg_rd_data, 8'hC1);
    wait_done(bd, 2000);
    chk("busy_len", last_run, 644);
    chk("first_rd_lat", first_rd_cyc - rise_cyc, 4);
    chk("req_in_start", req_at_rise, 0);
    chk("wr_count", wr_cnt - bw, 160);
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    #1 chk("req_idle", bus_req, 0);

    // echo mapping: F0 reads D000-D09F
    bd = done_cnt;
    push_xfer(8'hD0);
    cpu_wr(8'hF0);
    wait_done(bd, 2000);
    chk("echo_busy", last_run, 644);
    chk("echo_reg", reg_rd_data, 8'hF0);
    chk("echo_left", exp_wr.size(), 0);

    // grant stall of 7 cycles in byte 20's write cycle
    bd = done_cnt; br = rd_cnt;
    push_xfer(8'hC1);
    cpu_wr(8'hC1);
    wait_cnt(1'b0, br + 21, 2000);
    #1 bus_grant = 1'b0;
    repeat (7) @(posedge clk);
    #1 bus_grant = 1'b1;
    wait_done(bd, 2000);
    chk("stall_busy", last_run, 651);
    chk("stall_left", exp_wr.size(), 0);

    // restart at byte 30: C0 then C2, busy continuous
    bw = wr_cnt; bd = done_cnt;
    push_xfer(8'hC0);
    cpu_wr(8'hC0);
    wait_cnt(1'b1, bw + 30, 2000);
    exp_rd.delete(); exp_wr.delete();
    push_xfer(8'hC2);
    cpu_wr(8'hC2);
    wait_done(bd, 3000);
    chk("restart_busy", last_run, 768);
    chk("restart_wr", wr_cnt - bw, 190);
    chk("restart_reg", reg_rd_data, 8'hC2);
    chk("restart_left", exp_wr.size(), 0);

    // reset in the middle of a transfer
    bw = wr_cnt;
    push_xfer(8'hC1);
    cpu_wr(8'hC1);
    wait_cnt(1'b1, bw + 50, 2000);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);         chk("mid_req", bus_req, 0);
    chk("mid_rd_en", bus_rd_en, 0);   chk("mid_wr_en", oam_wr_en, 0);
    chk("mid_addr", bus_addr, 0);     chk("mid_oam_addr", oam_addr, 0);
    chk("mid_wdata", oam_wr_data, 0); chk("mid_reg", reg_rd_data, 8'hFF);
    exp_rd.delete(); exp_wr.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_reg", reg_rd_data, 8'hFF);

    // small instance: 1 byte, 2 cycles per byte, no start delay
    @(posedge clk); #1;
    s_reg_wr_en = 1'b1; s_reg_wr_data = 8'h45;
    @(posedge clk); #1;
    s_reg_wr_en = 1'b0;
    chk("s_c0_busy", s_busy, 1);      chk("s_c0_rd", s_bus_rd_en, 1);
    chk("s_c0_addr", s_bus_addr, 16'h4500); chk("s_c0_req", s_bus_req, 1);
    chk("s_c0_wr", s_oam_wr_en, 0);
    @(posedge clk); #1;
    chk("s_c1_busy", s_busy, 1);      chk("s_c1_rd", s_bus_rd_en, 0);
    chk("s_c1_wr", s_oam_wr_en, 1);
    chk("s_c1_wdata", {s_oam_addr, s_oam_wr_data}, 16'h0045);
    @(posedge clk); #1;
    chk("s_end_busy", s_busy, 0);     chk("s_end_req", s_bus_req, 0);
    chk("s_end_wr", s_oam_wr_en, 0);  chk("s_reg", s_reg_rd_data, 8'h45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
